fft_n_point_seq: RTL and testbench
==================================

# fft_n_point_seq

Sequential, parametrised N-point DFT engine that generalises the fixed combinational 11-point transform into a streaming, handshaked block. It accepts one complex sample per cycle into an internal frame buffer and computes each bin with one complex MAC per cycle from an elaboration-time twiddle ROM. It emits bins 0..N-1 in order with valid/ready backpressure and supports forward or inverse mode per frame. It sits between the sample front-end and the bin post-processing stage; its default parameters reproduce the 11-point datapath widths.

## Interface
- `N`, 11: transform length, 2..64; any N is allowed, not only powers of two.
- `WL`, 9: signed input word length, applied separately to the real and imaginary parts.
- `TW_WL`, 20: signed twiddle word length. Fractional bits F = TW_WL-2.
- `WL_out`, 34: signed output word length. Must satisfy WL_out ≥ WL+TW_WL+1+clog2(N).

- `clk` in 1: clock; every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: block can accept a sample.
- `in_r`, `in_i` in WL each: signed input sample.
- `inv` in 1: inverse mode, sampled with sample 0 of each frame.
- `out_valid` out 1: output bin valid.
- `out_ready` in 1: downstream accepts the bin.
- `out_r`, `out_i` out WL_out each: signed bin value.
- `out_k` out clog2(N): bin index.
- `out_last` out 1: asserted when out_k == N-1.

## Operation
- States and transitions:
  - LOAD goes to CALC on the accept of sample N-1.
  - CALC goes to OUT after N MAC cycles.
  - OUT, on handshake: returns to CALC with k+1, or to LOAD when k == N-1.
- Handshakes:
  - in_ready = (state==LOAD) & ~rst.
  - A sample is accepted when in_valid & in_ready; accepted samples are written to buffer[n], then n increments.
  - An output bin transfers when out_valid & out_ready.
- Frame mode:
  - frame_inv is latched from `inv` when sample 0 is accepted.
  - The `inv` value on samples 1..N-1 is ignored.
- Twiddle ROM:
  - C[m] = round(2^F·cos(2πm/N)) and S[m] = round(2^F·sin(2πm/N)), m = 0..N-1.
  - Built by a constant function at elaboration.
- Twiddle index:
  - idx = (k·n) mod N, maintained incrementally.
  - idx = 0 at n = 0; each step idx += k, and subtracts N when the result is ≥ N. No multiplier is used.
- MAC in CALC cycle n (accumulators cleared on CALC entry):
  - Forward: acc_r += xr·C + xi·S; acc_i += xi·C − xr·S.
  - Inverse: acc_r += xr·C − xi·S; acc_i += xi·C + xr·S.
- Width rules:
  - Products are full precision and sign-extended to WL_out.
  - No rounding, shifting or 1/N scaling; outputs carry a scale of 2^F.
  - Overflow cannot occur under the WL_out constraint.
- Output path:
  - out_r/out_i/out_k/out_last are registered and held stable while out_valid & ~out_ready.
  - The buffer is read-only outside LOAD, so a frame's bins never mix with the next frame's samples.

## Timing
- Reset values (one edge with rst=1):
  - State LOAD; n, k and idx = 0; accumulators 0.
  - out_valid = 0; out_r, out_i, out_k, out_last = 0; frame_inv = 0.
  - in_ready = 0 while rst is high and 1 on the first cycle after.
- Load: one sample per cycle at most; in_valid gaps are allowed.
- Latency: out_valid rises exactly N cycles after the edge that accepted sample N-1.
- Bin spacing: each subsequent bin becomes valid N cycles after the previous handshake edge.
- Throughput: with in_valid and out_ready held high, one frame takes N + N·(N+1) cycles.
- Next frame: in_ready reasserts in the cycle after the bin N-1 handshake.
- Reset mid-frame (LOAD, CALC or OUT):
  - The frame is discarded.
  - out_valid is 0 after the reset edge.
  - Partial buffer contents are never emitted.
- Simultaneous rst and handshake: rst wins, and the transfer is not counted.

## Test plan
- **Reset:** assert rst for 2 cycles mid-CALC. Required: out_valid=0, out_r=out_i=0 and in_ready=0 during reset; in_ready=1 on the next cycle; the next full frame is correct.
- **Impulse at n=0:** x0=(5,−3), other samples 0, forward. Required: every bin k=0..10 gives out_r=1310720 and out_i=−786432; out_last only on k=10; first out_valid N=11 cycles after the last accept.
- **Impulse at n=1, both modes:** x1=(1,0). Forward: bin k gives (C[k], −S[k]). Inverse: bin k gives (C[k], +S[k]). Bin 0 = (262144, 0) in both modes.
- **Full-scale DC:** all 11 samples = (−256, 0). Required: bin 0 = (−738197504, 0) with no wrap.
- **Backpressure:** hold out_ready low for 7 cycles on bin 3. Required: out_r, out_i, out_k = 3 and out_valid stable throughout; no bin is skipped or duplicated.
- **Back-to-back frames:** in_valid held high, with inv toggling between frames and on sample 5. Required: in_ready is low outside LOAD; each frame uses its own sample-0 inv value; bins match the golden model.

Source files
------------

// File: rtl/fft_n_point_seq.sv
// Sequential N-point DFT engine: buffers one frame of complex samples, then computes
// each bin with one complex MAC per cycle against an elaboration-time twiddle ROM.
module fft_n_point_seq #(
    parameter int N      = 11,
    parameter int WL     = 9,
    parameter int TW_WL  = 20,
    parameter int WL_out = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WL-1:0]     in_r,
    input  logic signed [WL-1:0]     in_i,
    input  logic                     inv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [WL_out-1:0] out_r,
    output logic signed [WL_out-1:0] out_i,
    output logic [$clog2(N)-1:0]     out_k,
    output logic                     out_last
);
    localparam int KW = $clog2(N);
    localparam int F  = TW_WL - 2;
    localparam real PI = 3.14159265358979323846;
    localparam logic [KW-1:0] LAST = KW'(N - 1);
    localparam logic [KW:0]   NN   = (KW + 1)'(N);

    // Round half away from zero.
    function automatic int round_fix(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic logic [N*TW_WL-1:0] build_rom(input bit want_sin);
        logic [N*TW_WL-1:0] rom;
        real ang;
        real v;
        rom = '0;
        for (int m = 0; m < N; m++) begin
            ang = 2.0 * PI * real'(m) / real'(N);
            v   = want_sin ? $sin(ang) : $cos(ang);
            rom[m*TW_WL +: TW_WL] = TW_WL'(round_fix(v * (2.0 ** F)));
        end
        return rom;
    endfunction

    localparam logic [N*TW_WL-1:0] COS_ROM = build_rom(1'b0);
    localparam logic [N*TW_WL-1:0] SIN_ROM = build_rom(1'b1);

    logic signed [TW_WL-1:0] cos_rom [N];
    logic signed [TW_WL-1:0] sin_rom [N];

    for (genvar m = 0; m < N; m++) begin : g_rom
        assign cos_rom[m] = COS_ROM[m*TW_WL +: TW_WL];
        assign sin_rom[m] = SIN_ROM[m*TW_WL +: TW_WL];
    end

    typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

    state_t                   state_q, state_d;
    logic [KW-1:0]            n_q, n_d;
    logic [KW-1:0]            k_q, k_d;
    logic [KW-1:0]            idx_q, idx_d;
    logic signed [WL_out-1:0] acc_r_q, acc_r_d;
    logic signed [WL_out-1:0] acc_i_q, acc_i_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [WL_out-1:0] out_r_q, out_r_d;
    logic signed [WL_out-1:0] out_i_q, out_i_d;
    logic [KW-1:0]            out_k_q, out_k_d;
    logic                     out_last_q, out_last_d;
    logic                     frame_inv_q, frame_inv_d;

    logic signed [WL-1:0] buf_r_q [N];
    logic signed [WL-1:0] buf_i_q [N];
    logic                 wr_en;

    logic signed [WL_out-1:0] xr, xi, tc, ts;
    logic signed [WL_out-1:0] p_rc, p_is, p_ic, p_rs;
    logic signed [WL_out-1:0] term_r, term_i;
    logic [KW:0]              idx_sum;
    logic [KW-1:0]            idx_next;

    assign in_ready  = (state_q == S_LOAD) && !rst;
    assign wr_en     = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign out_k     = out_k_q;
    assign out_last  = out_last_q;

    // Buffer is only written in LOAD, so bins of a frame never see the next frame's data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_r_q[n_q] <= in_r;
            buf_i_q[n_q] <= in_i;
        end
    end

    always_comb begin
        xr = WL_out'(buf_r_q[n_q]);
        xi = WL_out'(buf_i_q[n_q]);
        tc = WL_out'(cos_rom[idx_q]);
        ts = WL_out'(sin_rom[idx_q]);
        p_rc = xr * tc;
        p_is = xi * ts;
        p_ic = xi * tc;
        p_rs = xr * ts;
        term_r = frame_inv_q ? (p_rc - p_is) : (p_rc + p_is);
        term_i = frame_inv_q ? (p_ic + p_rs) : (p_ic - p_rs);
        // (k*n) mod N tracked by repeated addition of k.
        idx_sum  = {1'b0, idx_q} + {1'b0, k_q};
        idx_next = (idx_sum >= NN) ? KW'(idx_sum - NN) : KW'(idx_sum);
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        idx_d       = idx_q;
        acc_r_d     = acc_r_q;
        acc_i_d     = acc_i_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        out_k_d     = out_k_q;
        out_last_d  = out_last_q;
        frame_inv_d = frame_inv_q;
        case (state_q)
            S_LOAD: begin
                if (wr_en) begin
                    if (n_q == '0) frame_inv_d = inv;
                    if (n_q == LAST) begin
                        state_d = S_CALC;
                        n_d     = '0;
                        k_d     = '0;
                        idx_d   = '0;
                        acc_r_d = '0;
                        acc_i_d = '0;
                    end else begin
                        n_d = n_q + KW'(1);
                    end
                end
            end
            S_CALC: begin
                acc_r_d = acc_r_q + term_r;
                acc_i_d = acc_i_q + term_i;
                idx_d   = idx_next;
                n_d     = n_q + KW'(1);
                if (n_q == LAST) begin
                    state_d     = S_OUT;
                    n_d         = '0;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_r_d     = acc_r_d;
                    out_i_d     = acc_i_d;
                    out_k_d     = k_q;
                    out_last_d  = (k_q == LAST);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    n_d         = '0;
                    idx_d       = '0;
                    if (k_q == LAST) begin
                        state_d = S_LOAD;
                        k_d     = '0;
                    end else begin
                        state_d = S_CALC;
                        k_d     = k_q + KW'(1);
                        acc_r_d = '0;
                        acc_i_d = '0;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            n_q         <= '0;
            k_q         <= '0;
            idx_q       <= '0;
            acc_r_q     <= '0;
            acc_i_q     <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            out_k_q     <= '0;
            out_last_q  <= 1'b0;
            frame_inv_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            idx_q       <= idx_d;
            acc_r_q     <= acc_r_d;
            acc_i_q     <= acc_i_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
            out_k_q     <= out_k_d;
            out_last_q  <= out_last_d;
            frame_inv_q <= frame_inv_d;
        end
    end

endmodule

// File: tb/tb_fft_n_point_seq.sv
// Bench for fft_n_point_seq: directed vector table, reset/backpressure sequences,
// random and back-to-back frames checked against a direct DFT reference.
module tb_fft_n_point_seq;
    localparam int N      = 11;
    localparam int WL     = 9;
    localparam int TW_WL  = 20;
    localparam int WL_out = 34;
    localparam int KW     = $clog2(N);
    localparam int BOUND  = 4 * N + 20;
    localparam real PI    = 3.14159265358979323846;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [WL-1:0]     in_r;
    logic signed [WL-1:0]     in_i;
    logic                     inv;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [WL_out-1:0] out_r;
    logic signed [WL_out-1:0] out_i;
    logic [KW-1:0]            out_k;
    logic                     out_last;

    fft_n_point_seq #(.N(N), .WL(WL), .TW_WL(TW_WL), .WL_out(WL_out)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i), .inv(inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_r(out_r), .out_i(out_i), .out_k(out_k),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    int nchk;
    int nfail;

    logic signed [WL-1:0] smp_r [N];
    logic signed [WL-1:0] smp_i [N];
    longint er [N];
    longint ei [N];
    longint got_r [N];
    longint got_i [N];

    logic signed [WL-1:0] bb_r [3][N];
    logic signed [WL-1:0] bb_i [3][N];
    bit                   bb_inv [3];
    longint               bb_er [3][N];
    longint               bb_ei [3][N];

    typedef struct {
        string  name;
        int     kind;   // 0: single impulse at pos, 1: constant (DC) frame
        int     pos;
        int     vr;
        int     vi;
        bit     inv;
        int     chk_k;
        longint exp_r;
        longint exp_i;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint rnd(input real v);
        return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
    endfunction

    // Direct DFT with rounded twiddles, exponent index (k*n) mod N.
    task automatic model(input bit inv_m);
        real scale;
        scale = 2.0 ** (TW_WL - 2);
        for (int k = 0; k < N; k++) begin
            longint ar, ai, c, s, xr, xi;
            int m;
            ar = 0;
            ai = 0;
            for (int n = 0; n < N; n++) begin
                m  = (k * n) % N;
                c  = rnd($cos(2.0 * PI * real'(m) / real'(N)) * scale);
                s  = rnd($sin(2.0 * PI * real'(m) / real'(N)) * scale);
                xr = longint'(smp_r[n]);
                xi = longint'(smp_i[n]);
                if (!inv_m) begin
                    ar += xr * c + xi * s;
                    ai += xi * c - xr * s;
                end else begin
                    ar += xr * c - xi * s;
                    ai += xi * c + xr * s;
                end
            end
            er[k] = ar;
            ei[k] = ai;
        end
    endtask

    task automatic random_frame();
        for (int n = 0; n < N; n++) begin
            smp_r[n] = WL'($urandom);
            smp_i[n] = WL'($urandom);
        end
    endtask

    task automatic load_frame(input bit inv0, input bit gaps);
        int waitc;
        for (int n = 0; n < N; n++) begin
            in_valid = 1'b1;
            in_r     = smp_r[n];
            in_i     = smp_i[n];
            inv      = (n == 0) ? inv0 : 1'($urandom);
            waitc    = 0;
            while (!in_ready) begin
                @(posedge clk); #1;
                waitc++;
                if (waitc > BOUND) begin
                    check("load timeout in_ready", longint'(in_ready), 1);
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (gaps && n < N - 1 && $urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic collect_bins(input string tag, input bit chk_first, input int stall_k,
                                input int stall_len);
        int cnt;
        for (int k = 0; k < N; k++) begin
            cnt = 0;
            while (!out_valid) begin
                @(posedge clk); #1;
                cnt++;
                if (cnt > BOUND) begin
                    check($sformatf("%s bin%0d out_valid timeout", tag, k), longint'(out_valid), 1);
                    return;
                end
            end
            if (k > 0 || chk_first) check($sformatf("%s bin%0d latency", tag, k), cnt, N);
            check($sformatf("%s bin%0d in_ready", tag, k), longint'(in_ready), 0);
            check($sformatf("%s bin%0d out_k", tag, k), longint'(out_k), k);
            check($sformatf("%s bin%0d out_r", tag, k), out_r, er[k]);
            check($sformatf("%s bin%0d out_i", tag, k), out_i, ei[k]);
            check($sformatf("%s bin%0d out_last", tag, k), longint'(out_last), (k == N - 1) ? 1 : 0);
            got_r[k] = out_r;
            got_i[k] = out_i;
            if (k == stall_k) begin
                out_ready = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk); #1;
                    check($sformatf("%s stall valid", tag), longint'(out_valid), 1);
                    check($sformatf("%s stall out_k", tag), longint'(out_k), k);
                    check($sformatf("%s stall out_r", tag), out_r, er[k]);
                    check($sformatf("%s stall out_i", tag), out_i, ei[k]);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        check($sformatf("%s next-frame in_ready", tag), longint'(in_ready), 1);
    endtask

    task automatic set_vec(input vec_t v);
        for (int n = 0; n < N; n++) begin
            smp_r[n] = (v.kind == 1) ? WL'(v.vr) : '0;
            smp_i[n] = (v.kind == 1) ? WL'(v.vi) : '0;
        end
        if (v.kind == 0) begin
            smp_r[v.pos] = WL'(v.vr);
            smp_i[v.pos] = WL'(v.vi);
        end
    endtask

    task automatic wait_out_valid(input string tag);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt <= BOUND) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, " out_valid reached"}, longint'(out_valid), 1);
    endtask

    initial begin
        nchk = 0;
        nfail = 0;
        vecs[0] = '{"imp0 fwd k0", 0, 0, 5, -3, 1'b0, 0, 1310720, -786432};
        vecs[1] = '{"imp0 fwd k10", 0, 0, 5, -3, 1'b0, 10, 1310720, -786432};
        vecs[2] = '{"imp1 fwd k0", 0, 1, 1, 0, 1'b0, 0, 262144, 0};
        vecs[3] = '{"imp1 inv k0", 0, 1, 1, 0, 1'b1, 0, 262144, 0};
        vecs[4] = '{"dc fwd k0", 1, 0, -256, 0, 1'b0, 0, -738197504, 0};
        vecs[5] = '{"dc inv k0", 1, 0, -256, 0, 1'b1, 0, -738197504, 0};

        rst = 1'b1; in_valid = 1'b0; in_r = '0; in_i = '0; inv = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_r", out_r, 0);
        check("reset out_i", out_i, 0);
        check("reset out_k", longint'(out_k), 0);
        check("reset out_last", longint'(out_last), 0);
        check("reset in_ready", longint'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check("post-reset in_ready", longint'(in_ready), 1);

        for (int t = 0; t < 6; t++) begin
            set_vec(vecs[t]);
            model(vecs[t].inv);
            load_frame(vecs[t].inv, 1'b0);
            collect_bins(vecs[t].name, 1'b1, -1, 0);
            check({vecs[t].name, " table r"}, got_r[vecs[t].chk_k], vecs[t].exp_r);
            check({vecs[t].name, " table i"}, got_i[vecs[t].chk_k], vecs[t].exp_i);
        end

        // Reset held for two cycles in the middle of CALC.
        random_frame();
        load_frame(1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("calc-rst out_valid", longint'(out_valid), 0);
            check("calc-rst out_r", out_r, 0);
            check("calc-rst out_i", out_i, 0);
            check("calc-rst in_ready", longint'(in_ready), 0);
        end
        rst = 1'b0; #1;
        check("calc-rst in_ready after", longint'(in_ready), 1);
        random_frame();
        model(1'b1);
        load_frame(1'b1, 1'b1);
        collect_bins("after calc-rst", 1'b1, -1, 0);

        // Reset while a bin is presented with out_ready high: reset wins.
        random_frame();
        load_frame(1'b0, 1'b0);
        wait_out_valid("out-rst");
        rst = 1'b1;
        @(posedge clk); #1;
        check("out-rst out_valid", longint'(out_valid), 0);
        check("out-rst in_ready", longint'(in_ready), 0);
        rst = 1'b0; #1;
        check("out-rst in_ready after", longint'(in_ready), 1);
        random_frame();
        model(1'b0);
        load_frame(1'b0, 1'b0);
        collect_bins("after out-rst", 1'b1, -1, 0);

        // Backpressure on bin 3 for 7 cycles.
        random_frame();
        model(1'b1);
        load_frame(1'b1, 1'b0);
        collect_bins("backpressure", 1'b1, 3, 7);

        for (int r = 0; r < 4; r++) begin
            bit iv;
            iv = 1'($urandom);
            random_frame();
            model(iv);
            load_frame(iv, 1'b1);
            collect_bins($sformatf("rand%0d", r), 1'b1, (r == 2) ? int'($urandom_range(0, N - 1)) : -1, 2);
        end

        // Back-to-back frames with in_valid held high and inv toggling.
        bb_inv[0] = 1'b0; bb_inv[1] = 1'b1; bb_inv[2] = 1'b0;
        for (int f = 0; f < 3; f++) begin
            random_frame();
            model(bb_inv[f]);
            for (int n = 0; n < N; n++) begin
                bb_r[f][n]  = smp_r[n];
                bb_i[f][n]  = smp_i[n];
                bb_er[f][n] = er[n];
                bb_ei[f][n] = ei[n];
            end
        end
        fork
            begin : drv
                int waitc;
                for (int f = 0; f < 3; f++) begin
                    for (int n = 0; n < N; n++) begin
                        in_valid = 1'b1;
                        in_r     = bb_r[f][n];
                        in_i     = bb_i[f][n];
                        inv      = (n == 5) ? ~bb_inv[f] : bb_inv[f];
                        waitc    = 0;
                        while (!in_ready && waitc <= 4 * BOUND) begin
                            @(posedge clk); #1;
                            waitc++;
                        end
                        if (!in_ready) check("b2b load timeout in_ready", longint'(in_ready), 1);
                        @(posedge clk); #1;
                    end
                end
                in_valid = 1'b0;
            end
            begin : mon
                for (int f = 0; f < 3; f++) begin
                    for (int k = 0; k < N; k++) begin
                        er[k] = bb_er[f][k];
                        ei[k] = bb_ei[f][k];
                    end
                    collect_bins($sformatf("b2b f%0d", f), 1'b0, -1, 0);
                end
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
